// File: rtl/exec_datapath_if.sv
// Issue/result/load-writeback bundle between the decode controller and exec_datapath.
interface exec_datapath_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RAW = $clog2(NREGS);

    logic            in_valid;
    logic            in_ready;
    logic [RAW-1:0]  rs_1;
    logic [RAW-1:0]  rs_2;
    logic [RAW-1:0]  rd_0;
    logic            write_rb;
    logic            alu_source;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] immediate;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            negative;
    logic            overflow;
    logic            zero;
    logic            wb_en;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output in_valid, rs_1, rs_2, rd_0, write_rb, alu_source, alu_control, immediate,
        output out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, alu_result, negative, overflow, zero
    );

    modport slave (
        input  in_valid, rs_1, rs_2, rd_0, write_rb, alu_source, alu_control, immediate,
        input  out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, alu_result, negative, overflow, zero
    );
endinterface

// File: rtl/exec_datapath.sv
// Register file plus one registered ALU stage with valid/ready issue and result handshake.
// Define EXEC_DATAPATH_FWD_EN to forward the held result instead of stalling on RAW hazards.
module exec_datapath #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic            clk,
    input logic            rst_n,
    exec_datapath_if.slave dp
);
    localparam int RAW = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] res_q, res_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic            hwr_q, hwr_d;
    logic [RAW-1:0]  hrd_q, hrd_d;

    logic            issue;
    logic            retire;
    logic            rt_wr;
    logic            wb_wr;
    logic            held_wr;
    logic            haz_a;
    logic            haz_b;
    logic            stall;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] alu_r;
    logic            alu_ovf;

    assign rf_a = regs_q[dp.rs_1];
    assign rf_b = regs_q[dp.rs_2];

    // Only an entry that will actually write a non-zero register can conflict.
    assign held_wr = out_valid_q && hwr_q && (hrd_q != '0);
    assign haz_a   = held_wr && (hrd_q == dp.rs_1);
    assign haz_b   = held_wr && dp.alu_source && (hrd_q == dp.rs_2);

`ifdef EXEC_DATAPATH_FWD_EN
    assign op_a  = haz_a ? res_q : rf_a;
    assign src_b = haz_b ? res_q : rf_b;
    assign stall = 1'b0;
`else
    assign op_a  = rf_a;
    assign src_b = rf_b;
    assign stall = haz_a || haz_b;
`endif

    assign op_b = dp.alu_source ? src_b : dp.immediate;
    assign sh   = op_b[SHW-1:0];

    always_comb begin
        alu_r   = '0;
        alu_ovf = 1'b0;
        unique case (dp.alu_control)
            OP_ADD: begin
                alu_r   = op_a + op_b;
                alu_ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (alu_r[XLEN-1] != op_a[XLEN-1]);
            end
            OP_SUB: begin
                alu_r   = op_a - op_b;
                alu_ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (alu_r[XLEN-1] != op_a[XLEN-1]);
            end
            OP_AND:  alu_r = op_a & op_b;
            OP_OR:   alu_r = op_a | op_b;
            OP_XOR:  alu_r = op_a ^ op_b;
            OP_SLL:  alu_r = op_a << sh;
            OP_SRL:  alu_r = op_a >> sh;
            OP_SRA:  alu_r = $unsigned($signed(op_a) >>> sh);
            default: alu_r = '0;
        endcase
    end

    assign dp.in_ready = (!out_valid_q || dp.out_ready) && !stall;
    assign issue       = dp.in_valid && dp.in_ready;
    assign retire      = out_valid_q && dp.out_ready;
    assign rt_wr       = retire && hwr_q && (hrd_q != '0);
    assign wb_wr       = dp.wb_en && (dp.wb_rd != '0);

    always_comb begin
        res_d       = res_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        hwr_d       = hwr_q;
        hrd_d       = hrd_q;
        if (issue) begin
            res_d       = alu_r;
            neg_d       = alu_r[XLEN-1];
            ovf_d       = alu_ovf;
            zero_d      = (alu_r == '0);
            out_valid_d = 1'b1;
            hwr_d       = dp.write_rb;
            hrd_d       = dp.rd_0;
        end else if (retire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            hwr_q       <= 1'b0;
            hrd_q       <= '0;
        end else begin
            res_q       <= res_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            hwr_q       <= hwr_d;
            hrd_q       <= hrd_d;
        end
    end

    // Retire write has priority over a load write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (rt_wr && (hrd_q == RAW'(i))) begin
                    regs_q[i] <= res_q;
                end else if (wb_wr && (dp.wb_rd == RAW'(i))) begin
                    regs_q[i] <= dp.wb_data;
                end
            end
        end
    end

    assign dp.out_valid  = out_valid_q;
    assign dp.alu_result = res_q;
    assign dp.negative   = neg_q;
    assign dp.overflow   = ovf_q;
    assign dp.zero       = zero_q;
endmodule
